// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: control FSM for the switch calculator datapath.
// Steps through operand A capture, operand B capture, operation select,
// an ALU run with a start/done handshake and timeout, and a result display
// state. It also steers the display mux automatically on each transition.
// Every output comes straight from a flop.
module calc_op_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_p,
    input  logic       op_p,
    input  logic       disp_p,
    input  logic       alu_done,
    output logic       load_a,
    output logic       load_b,
    output logic [1:0] alu_sel,
    output logic       alu_start,
    output logic       result_load,
    output logic [1:0] disp_sel,
    output logic       busy,
    output logic       err,
    output logic [2:0] state
);

    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        GET_A  = 3'b000,
        GET_B  = 3'b001,
        SEL_OP = 3'b010,
        RUN    = 3'b011,
        SHOW   = 3'b100
    } state_t;

    localparam logic [1:0] SEL_CLEAR = 2'b00;
    localparam logic [1:0] SEL_ADD   = 2'b01;
    localparam logic [1:0] DISP_ZERO = 2'b00;
    localparam logic [1:0] DISP_A    = 2'b01;
    localparam logic [1:0] DISP_B    = 2'b10;
    localparam logic [1:0] DISP_RES  = 2'b11;

    state_t        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_a_d, load_b_d, alu_start_d, result_load_d;
    logic          busy_d, err_d;
    logic [1:0]    alu_sel_d, disp_sel_d;

    // State, counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= GET_A;
            cnt_q       <= '0;
            load_a      <= 1'b0;
            load_b      <= 1'b0;
            alu_start   <= 1'b0;
            result_load <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            alu_sel     <= SEL_ADD;
            disp_sel    <= DISP_ZERO;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            load_a      <= load_a_d;
            load_b      <= load_b_d;
            alu_start   <= alu_start_d;
            result_load <= result_load_d;
            busy        <= busy_d;
            err         <= err_d;
            alu_sel     <= alu_sel_d;
            disp_sel    <= disp_sel_d;
        end
    end

    // Next state and next output values
    always_comb begin
        st_d          = st_q;
        cnt_d         = cnt_q;
        load_a_d      = 1'b0;
        load_b_d      = 1'b0;
        alu_start_d   = 1'b0;
        result_load_d = 1'b0;
        err_d         = err;
        alu_sel_d     = alu_sel;
        disp_sel_d    = disp_sel;

        // Manual display stepping; the per-state automatic writes below
        // come later, so they take priority over a coincident disp_p.
        if (st_q != RUN && disp_p) begin
            disp_sel_d = disp_sel + 2'd1;
        end

        case (st_q)
            GET_A: begin
                if (enter_p) begin
                    load_a_d   = 1'b1;
                    disp_sel_d = DISP_A;
                    st_d       = GET_B;
                end
            end
            GET_B: begin
                if (enter_p) begin
                    load_b_d   = 1'b1;
                    disp_sel_d = DISP_B;
                    st_d       = SEL_OP;
                end
            end
            SEL_OP: begin
                if (enter_p) begin
                    if (alu_sel == SEL_CLEAR) begin
                        // Clear needs no ALU cycles; latch the result now.
                        result_load_d = 1'b1;
                        disp_sel_d    = DISP_RES;
                        st_d          = SHOW;
                    end else begin
                        alu_start_d = 1'b1;
                        cnt_d       = '0;
                        st_d        = RUN;
                    end
                end else if (op_p) begin
                    alu_sel_d = alu_sel + 2'd1;
                end
            end
            RUN: begin
                if (alu_done) begin
                    result_load_d = 1'b1;
                    disp_sel_d    = DISP_RES;
                    cnt_d         = '0;
                    st_d          = SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    disp_sel_d = DISP_RES;
                    cnt_d      = '0;
                    st_d       = SHOW;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHOW: begin
                if (enter_p) begin
                    err_d      = 1'b0;
                    disp_sel_d = DISP_ZERO;
                    st_d       = GET_A;
                end
            end
            default: begin
                st_d  = GET_A;
                cnt_d = '0;
            end
        endcase

        busy_d = (st_d == RUN);
    end

    assign state = st_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed scenarios with literal expectations,
// then randomized button/ALU traffic. A behavioural model is compared with
// the DUT outputs after every clock edge.
module tb_calc_op_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter_p = 1'b0, op_p = 1'b0, disp_p = 1'b0, alu_done = 1'b0;
    logic       load_a, load_b, alu_start, result_load, busy, err;
    logic [1:0] alu_sel, disp_sel;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    calc_op_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enter_p(enter_p), .op_p(op_p),
        .disp_p(disp_p), .alu_done(alu_done), .load_a(load_a),
        .load_b(load_b), .alu_sel(alu_sel), .alu_start(alu_start),
        .result_load(result_load), .disp_sel(disp_sel), .busy(busy),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases: 0 wait A, 1 wait B, 2 choose op, 3 ALU running, 4 show result.
    int         m_phase;
    int         m_wait;     // cycles spent waiting for the ALU so far
    logic [1:0] m_sel, m_disp;
    logic       m_err, m_la, m_lb, m_as, m_rl;

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_sel = 2'b01; m_disp = 2'b00;
        m_err = 1'b0; m_la = 1'b0; m_lb = 1'b0; m_as = 1'b0; m_rl = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic o, input logic d, input logic dn);
        m_la = 1'b0; m_lb = 1'b0; m_as = 1'b0; m_rl = 1'b0;
        if (m_phase != 3 && d) m_disp = m_disp + 2'd1;
        case (m_phase)
            0: if (e) begin m_la = 1'b1; m_disp = 2'd1; m_phase = 1; end
            1: if (e) begin m_lb = 1'b1; m_disp = 2'd2; m_phase = 2; end
            2: begin
                if (e && m_sel == 2'd0) begin
                    m_rl = 1'b1; m_disp = 2'd3; m_phase = 4;
                end else if (e) begin
                    m_as = 1'b1; m_wait = 0; m_phase = 3;
                end else if (o) begin
                    m_sel = m_sel + 2'd1;
                end
            end
            3: begin
                m_wait = m_wait + 1;
                if (dn) begin
                    m_rl = 1'b1; m_disp = 2'd3; m_phase = 4;
                end else if (m_wait >= TO) begin
                    m_err = 1'b1; m_disp = 2'd3; m_phase = 4;
                end
            end
            default: if (e) begin m_err = 1'b0; m_disp = 2'd0; m_phase = 0; end
        endcase
    endtask

    // Compare process: advance the model on each edge, check the DUT just after.
    initial begin
        logic [12:0] got, exp;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step(enter_p, op_p, disp_p, alu_done);
            #1;
            exp = {3'(m_phase), m_sel, m_disp, (m_phase == 3), m_err, m_la, m_lb, m_as, m_rl};
            got = {state, alu_sel, disp_sel, busy, err, load_a, load_b, alu_start, result_load};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got %b expected %b (st,sel,disp,busy,err,la,lb,start,rl)",
                         $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic o, input logic d, input logic dn);
        @(negedge clk);
        enter_p = e; op_p = o; disp_p = d; alu_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enter_p = 1'b0; op_p = 1'b0; disp_p = 1'b0; alu_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cd;
        do_reset();
        chk("reset_state", state, 0);
        chk("reset_alu_sel", alu_sel, 1);
        chk("reset_disp_sel", disp_sel, 0);
        chk("reset_pulses", {load_a, load_b, alu_start, result_load, busy, err}, 0);

        // Clear op: step select three times from add, then enter.
        cyc(1, 0, 0, 0);
        chk("load_a_pulse", load_a, 1);
        chk("disp_after_a", disp_sel, 1);
        cyc(0, 0, 0, 0);
        chk("load_a_one_cycle", load_a, 0);
        cyc(1, 0, 0, 0);
        chk("load_b_pulse", load_b, 1);
        chk("state_sel_op", state, 2);
        repeat (3) cyc(0, 1, 0, 0);
        chk("op_wrap_to_clear", alu_sel, 0);
        cyc(1, 0, 0, 0);
        chk("clear_result_load", result_load, 1);
        chk("clear_no_start", alu_start, 0);
        chk("clear_state_show", state, 4);

        // Subtract with done five cycles after start.
        do_reset();
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
        chk("sub_alu_sel", alu_sel, 2);
        chk("sub_alu_start", alu_start, 1);
        chk("sub_busy", busy, 1);
        repeat (4) cyc(0, 0, 0, 0);
        chk("start_one_cycle", alu_start, 0);
        chk("no_early_result", result_load, 0);
        cyc(0, 0, 0, 1);
        chk("done_result_load", result_load, 1);
        chk("done_disp_res", disp_sel, 3);
        chk("done_state_show", state, 4);

        // Timeout: alu_sel retained as subtract.
        cyc(1, 0, 0, 0);
        chk("show_exit_state", state, 0);
        chk("show_exit_sel_kept", alu_sel, 2);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        repeat (TO - 1) cyc(0, 0, 0, 0);
        chk("pre_timeout_err", err, 0);
        chk("pre_timeout_state", state, 3);
        cyc(0, 0, 0, 0);
        chk("timeout_err", err, 1);
        chk("timeout_no_result", result_load, 0);
        chk("timeout_state", state, 4);
        cyc(1, 0, 0, 0);
        chk("err_cleared", err, 0);
        chk("err_clear_state", state, 0);

        // enter+op together, disp_p during RUN.
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("enter_wins_sel", alu_sel, 2);
        chk("enter_wins_start", alu_start, 1);
        cyc(0, 0, 1, 0);
        chk("disp_ignored_run", disp_sel, 2);
        cyc(0, 0, 0, 1);
        chk("state_show_again", state, 4);

        // Reset mid-RUN with done right after release.
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1; alu_done = 1'b1;
        @(posedge clk);
        #1;
        chk("abandoned_no_result", result_load, 0);
        chk("abandoned_state", state, 0);
        cyc(0, 0, 0, 0);

        // Randomized traffic with an ALU that sometimes never answers.
        cd = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 599) != 0);
            enter_p = ($urandom_range(0, 3) == 0);
            op_p    = ($urandom_range(0, 3) == 0);
            disp_p  = ($urandom_range(0, 4) == 0);
            if (alu_start) cd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 1));
            alu_done = (cd == 0) || ($urandom_range(0, 40) == 0);
            if (cd >= 0) cd--;
        end
        @(negedge clk);
        rst_n = 1'b1; enter_p = 1'b0; op_p = 1'b0; disp_p = 1'b0; alu_done = 1'b0;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
